// File: rtl/bp_cc_mem_rr_arbiter_pkg.sv
// Shared types and width helper for the core-complex memory-command arbiter
// and other blocks indexed by cc_x_dim.
package bp_cc_mem_rr_arbiter_pkg;

  typedef enum logic {
    e_arb_idle   = 1'b0,
    e_arb_locked = 1'b1
  } arb_state_e;

  // Requester-ID width; a single requester still gets a 1-bit ID.
  function automatic int lg_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cc_mem_rr_arbiter_if.sv
// Bundle of requester-side and downstream-side beat channels of the arbiter.
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// valid must not depend on ready, and a raised valid holds until accepted.
interface bp_cc_mem_rr_arbiter_if
  import bp_cc_mem_rr_arbiter_pkg::*;
#(
  parameter int cc_x_dim_p   = 2,
  parameter int data_width_p = 64,
  localparam int lg_cc_x_dim_lp = lg_width(cc_x_dim_p)
);

  logic [cc_x_dim_p*data_width_p-1:0] in_data_i;
  logic [cc_x_dim_p-1:0]              in_v_i;
  logic [cc_x_dim_p-1:0]              in_last_i;
  logic [cc_x_dim_p-1:0]              in_ready_o;
  logic [data_width_p-1:0]            out_data_o;
  logic [lg_cc_x_dim_lp-1:0]          out_id_o;
  logic                               out_last_o;
  logic                               out_v_o;
  logic                               out_ready_i;

  modport slave (
    input  in_data_i, in_v_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_id_o, out_last_o, out_v_o
  );

  modport master (
    output in_data_i, in_v_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_id_o, out_last_o, out_v_o
  );

endinterface

// File: rtl/bp_cc_mem_rr_arbiter_prio_enc.sv
// Round-robin priority encoder: first valid requester at or after rr_ptr_i,
// wrapping modulo cc_x_dim_p (which need not be a power of two).
module bp_cc_mem_rr_arbiter_prio_enc
  import bp_cc_mem_rr_arbiter_pkg::*;
#(
  parameter int cc_x_dim_p = 2,
  localparam int lg_lp = lg_width(cc_x_dim_p)
) (
  input  logic [cc_x_dim_p-1:0] v_i,
  input  logic [lg_lp-1:0]      rr_ptr_i,
  output logic [lg_lp-1:0]      grant_o,
  output logic                  grant_v_o
);

  int idx;

  always_comb begin
    grant_o   = '0;
    grant_v_o = 1'b0;
    idx       = 0;
    for (int k = 0; k < cc_x_dim_p; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= cc_x_dim_p) idx = idx - cc_x_dim_p;
      for (int j = 0; j < cc_x_dim_p; j++) begin
        if (!grant_v_o && (j == idx) && v_i[j]) begin
          grant_o   = lg_lp'(j);
          grant_v_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bp_cc_mem_rr_arbiter.sv
// Round-robin arbiter merging per-core-complex memory-command packets onto one
// registered channel; a grant is held until the last beat of the packet.
module bp_cc_mem_rr_arbiter
  import bp_cc_mem_rr_arbiter_pkg::*;
#(
  parameter int cc_x_dim_p   = 2,
  parameter int data_width_p = 64,
  localparam int lg_cc_x_dim_lp = lg_width(cc_x_dim_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_cc_mem_rr_arbiter_if.slave   bus,
  output logic                    locked_o,
  output arb_state_e              state_o
);

  arb_state_e                state_q, state_d;
  logic [lg_cc_x_dim_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [lg_cc_x_dim_lp-1:0] owner_q, owner_d;
  logic [data_width_p-1:0]   out_data_q, out_data_d;
  logic [lg_cc_x_dim_lp-1:0] out_id_q, out_id_d;
  logic                      out_last_q, out_last_d;
  logic                      out_v_q, out_v_d;

  logic [lg_cc_x_dim_lp-1:0] grant;
  logic                      grant_v;
  logic [lg_cc_x_dim_lp-1:0] sel_id;
  logic [data_width_p-1:0]   sel_data;
  logic                      sel_last;
  logic                      space;
  logic                      accept;
  logic [cc_x_dim_p-1:0]     in_ready;

  bp_cc_mem_rr_arbiter_prio_enc #(.cc_x_dim_p(cc_x_dim_p)) u_prio (
    .v_i       (bus.in_v_i),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (grant),
    .grant_v_o (grant_v)
  );

  always_comb begin
    space    = ~out_v_q | bus.out_ready_i;
    sel_id   = (state_q == e_arb_locked) ? owner_q : grant;
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    accept   = 1'b0;
    for (int i = 0; i < cc_x_dim_p; i++) begin
      if (sel_id == lg_cc_x_dim_lp'(i)) begin
        sel_data = bus.in_data_i[i*data_width_p +: data_width_p];
        sel_last = bus.in_last_i[i];
        // Owner stays ready through gaps in LOCKED; IDLE needs a live grant.
        if (!reset_i && space && ((state_q == e_arb_locked) || grant_v)) begin
          in_ready[i] = 1'b1;
          accept      = bus.in_v_i[i];
        end
      end
    end

    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    out_last_d = out_last_q;
    out_v_d    = out_v_q;
    if (accept) begin
      out_data_d = sel_data;
      out_id_d   = sel_id;
      out_last_d = sel_last;
      out_v_d    = 1'b1;
      if (sel_last) begin
        state_d  = e_arb_idle;
        rr_ptr_d = (sel_id == lg_cc_x_dim_lp'(cc_x_dim_p - 1)) ? '0
                                                                : sel_id + lg_cc_x_dim_lp'(1);
      end else begin
        state_d = e_arb_locked;
        owner_d = sel_id;
      end
    end else if (bus.out_ready_i) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_arb_idle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
      out_last_q <= 1'b0;
      out_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      out_last_q <= out_last_d;
      out_v_q    <= out_v_d;
    end
  end

  assign bus.in_ready_o = in_ready;
  assign bus.out_data_o = out_data_q;
  assign bus.out_id_o   = out_id_q;
  assign bus.out_last_o = out_last_q;
  assign bus.out_v_o    = out_v_q;
  assign locked_o       = (state_q == e_arb_locked);
  assign state_o        = state_q;

endmodule

// File: tb/tb_bp_cc_mem_rr_arbiter.sv
// Directed bench: a 3-requester arbiter driven from a per-cycle vector table,
// plus a hand-written back-to-back packet sequence on a 1-requester arbiter.
module tb_bp_cc_mem_rr_arbiter;
  import bp_cc_mem_rr_arbiter_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic       rst;
    logic [2:0] v;
    logic [2:0] last;
    logic       ordy;
    logic [2:0] exp_rdy;
    logic       exp_v;
    logic [1:0] exp_id;
    logic       exp_last;
    logic       exp_lock;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst3, rst1;
  logic       lock3, lock1;
  arb_state_e st3, st1;
  int         checks = 0;
  int         errors = 0;
  vec_t       vq[$];
  logic [W-1:0] exp_data;

  always #5 clk = ~clk;

  bp_cc_mem_rr_arbiter_if #(.cc_x_dim_p(3), .data_width_p(W)) b3 ();
  bp_cc_mem_rr_arbiter_if #(.cc_x_dim_p(1), .data_width_p(W)) b1 ();

  bp_cc_mem_rr_arbiter #(.cc_x_dim_p(3), .data_width_p(W)) dut3 (
    .clk_i(clk), .reset_i(rst3), .bus(b3.slave), .locked_o(lock3), .state_o(st3)
  );
  bp_cc_mem_rr_arbiter #(.cc_x_dim_p(1), .data_width_p(W)) dut1 (
    .clk_i(clk), .reset_i(rst1), .bus(b1.slave), .locked_o(lock1), .state_o(st1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] v, input logic [2:0] last,
                     input logic ordy, input logic [2:0] exp_rdy, input logic exp_v,
                     input logic [1:0] exp_id, input logic exp_last, input logic exp_lock);
    vec_t t;
    t.rst = rst; t.v = v; t.last = last; t.ordy = ordy; t.exp_rdy = exp_rdy;
    t.exp_v = exp_v; t.exp_id = exp_id; t.exp_last = exp_last; t.exp_lock = exp_lock;
    vq.push_back(t);
  endtask

  initial begin
    //   rst  v       last    ordy rdy     ov  id  lst lk
    add(1, 3'b111, 3'b111, 1, 3'b000, 0, 0, 0, 0);   // reset state
    add(0, 3'b111, 3'b111, 1, 3'b001, 1, 0, 1, 0);   // round robin 0,1,2,0,1,2
    add(0, 3'b111, 3'b111, 1, 3'b010, 1, 1, 1, 0);
    add(0, 3'b111, 3'b111, 1, 3'b100, 1, 2, 1, 0);
    add(0, 3'b111, 3'b111, 1, 3'b001, 1, 0, 1, 0);
    add(0, 3'b111, 3'b111, 1, 3'b010, 1, 1, 1, 0);
    add(0, 3'b111, 3'b111, 1, 3'b100, 1, 2, 1, 0);
    add(0, 3'b101, 3'b100, 1, 3'b001, 1, 0, 0, 1);   // req0 4-beat packet, req2 waiting
    add(0, 3'b101, 3'b100, 1, 3'b001, 1, 0, 0, 1);
    add(0, 3'b101, 3'b100, 1, 3'b001, 1, 0, 0, 1);
    add(0, 3'b101, 3'b101, 1, 3'b001, 1, 0, 1, 0);
    add(0, 3'b100, 3'b100, 1, 3'b100, 1, 2, 1, 0);   // req2 finally served
    add(0, 3'b010, 3'b000, 0, 3'b000, 1, 2, 1, 0);   // backpressure holds output
    add(0, 3'b010, 3'b000, 0, 3'b000, 1, 2, 1, 0);
    add(0, 3'b010, 3'b000, 1, 3'b010, 1, 1, 0, 1);   // drain+load same cycle
    add(0, 3'b101, 3'b101, 1, 3'b010, 0, 0, 0, 1);   // owner gap keeps lock
    add(0, 3'b010, 3'b010, 1, 3'b010, 1, 1, 1, 0);   // rr_ptr -> 2
    add(0, 3'b011, 3'b011, 1, 3'b001, 1, 0, 1, 0);   // wrap 2 -> 0
    add(0, 3'b011, 3'b011, 1, 3'b010, 1, 1, 1, 0);   // rr_ptr was 1
    add(0, 3'b000, 3'b000, 1, 3'b000, 0, 0, 0, 0);
    add(0, 3'b010, 3'b000, 1, 3'b010, 1, 1, 0, 1);   // req1 beat0 of 4
    add(0, 3'b010, 3'b000, 1, 3'b010, 1, 1, 0, 1);   // beat1
    add(1, 3'b010, 3'b000, 1, 3'b000, 0, 0, 0, 0);   // reset mid-packet
    add(0, 3'b010, 3'b000, 1, 3'b010, 1, 1, 0, 1);   // re-sent beat0 is a new packet
    add(0, 3'b010, 3'b010, 1, 3'b010, 1, 1, 1, 0);
    add(0, 3'b000, 3'b000, 1, 3'b000, 0, 0, 0, 0);

    rst3 = 1'b1; rst1 = 1'b1;
    b3.in_v_i = '0; b3.in_last_i = '0; b3.in_data_i = '0; b3.out_ready_i = 1'b1;
    b1.in_v_i = 1'b1; b1.in_last_i = '0; b1.in_data_i = '0; b1.out_ready_i = 1'b1;
    exp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("n1_reset_ready", 32'(b1.in_ready_o), 32'h0);
    chk("n1_reset_v", 32'(b1.out_v_o), 32'h0);
    chk("n1_reset_lock", 32'(lock1), 32'h0);
    rst1 = 1'b0; b1.in_v_i = 1'b0;

    for (int r = 0; r < vq.size(); r++) begin
      rst3 = vq[r].rst;
      b3.in_v_i = vq[r].v;
      b3.in_last_i = vq[r].last;
      b3.out_ready_i = vq[r].ordy;
      for (int i = 0; i < 3; i++) b3.in_data_i[i*W +: W] = W'((i + 1) * 16'h1000 + r);
      #2;
      chk($sformatf("row%0d_in_ready", r), 32'(b3.in_ready_o), 32'(vq[r].exp_rdy));
      for (int i = 0; i < 3; i++)
        if (!vq[r].rst && vq[r].exp_rdy[i] && vq[r].v[i]) exp_data = W'((i + 1) * 16'h1000 + r);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_out_v", r), 32'(b3.out_v_o), 32'(vq[r].exp_v));
      chk($sformatf("row%0d_locked", r), 32'(lock3), 32'(vq[r].exp_lock));
      chk($sformatf("row%0d_state", r), 32'(st3), vq[r].exp_lock ? 32'(e_arb_locked) : 32'(e_arb_idle));
      if (vq[r].exp_v) begin
        chk($sformatf("row%0d_out_id", r), 32'(b3.out_id_o), 32'(vq[r].exp_id));
        chk($sformatf("row%0d_out_last", r), 32'(b3.out_last_o), 32'(vq[r].exp_last));
        chk($sformatf("row%0d_out_data", r), 32'(b3.out_data_o), 32'(exp_data));
      end
    end

    // Single requester: three 2-beat packets back to back, no bubbles.
    b3.in_v_i = '0;
    for (int k = 0; k < 6; k++) begin
      b1.in_v_i = 1'b1;
      b1.in_last_i = 1'(k % 2);
      b1.in_data_i = W'(16'hD000 + k);
      b1.out_ready_i = 1'b1;
      #2;
      chk($sformatf("n1_beat%0d_ready", k), 32'(b1.in_ready_o), 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("n1_beat%0d_v", k), 32'(b1.out_v_o), 32'h1);
      chk($sformatf("n1_beat%0d_id", k), 32'(b1.out_id_o), 32'h0);
      chk($sformatf("n1_beat%0d_last", k), 32'(b1.out_last_o), 32'(k % 2));
      chk($sformatf("n1_beat%0d_lock", k), 32'(lock1), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("n1_beat%0d_data", k), 32'(b1.out_data_o), 32'(16'hD000 + k));
    end
    b1.in_v_i = 1'b0;
    @(posedge clk);
    #1;
    chk("n1_drain_v", 32'(b1.out_v_o), 32'h0);
    chk("n1_drain_lock", 32'(lock1), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
